char_sprite_renderer_reg: RTL and testbench

- Registered, parametrised next-generation character renderer for the VGA fighting-game pipeline.
- Draws the body (hurtbox) and the attack hitbox. Hitbox size and colours are parameters, and the hitbox flips side with facing direction.
- Character state is latched once per frame into shadow registers, so nothing tears mid-frame.
- Adds a frame-counted hurt-flash after a hit. Feeds the graphics mixer with 1-cycle latency.

---
 rtl/char_sprite_renderer_reg.sv | 163 ++++++++++++++++
 tb/tb_char_sprite_renderer_reg.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_sprite_renderer_reg.sv
// Character renderer with per-frame shadow latch, side-flipping attack hitbox
// and frame-counted hurt flash. Pixel decision is registered (1-cycle latency).
module char_sprite_renderer_reg #(
  parameter int unsigned COORD_W        = 10,
  parameter int unsigned HITBOX_W       = 32,
  parameter int unsigned HITBOX_H       = 8,
  parameter int unsigned FLASH_FRAMES   = 16,
  parameter int unsigned FLASH_PERIOD   = 4,
  parameter logic [7:0]  HURT_COLOR     = 8'hFF,
  parameter logic [7:0]  STARTUP_COLOR  = 8'b000_000_11,
  parameter logic [7:0]  ACTIVE_COLOR   = 8'b111_000_00,
  parameter logic [7:0]  RECOVERY_COLOR = 8'b000_111_00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start_in,
  input  logic               display_enable,
  input  logic [COORD_W-1:0] current_pixel_x,
  input  logic [COORD_W-1:0] current_pixel_y,
  input  logic [COORD_W-1:0] char_x_pos_in,
  input  logic [COORD_W-1:0] char_y_pos_in,
  input  logic [COORD_W-1:0] char_width_in,
  input  logic [COORD_W-1:0] char_height_in,
  input  logic [7:0]         char_color_in_332,
  input  logic [1:0]         attack_phase_in,
  input  logic               facing_left_in,
  input  logic               hit_pulse_in,
  output logic [7:0]         char_pixel_color_out_332,
  output logic               char_is_visible_at_pixel_out,
  output logic               flash_active_out
);

  localparam int unsigned GW   = COORD_W + 2;
  localparam int unsigned PBIT = $clog2(FLASH_PERIOD);
  localparam logic [0:0]  IDLE     = 1'b0;
  localparam logic [0:0]  FLASHING = 1'b1;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [7:0]         color_q, color_d;
  logic [1:0]         phase_q, phase_d;
  logic               facing_q, facing_d;
  logic [0:0]         state_q, state_d;
  logic [7:0]         elapsed_q, elapsed_d;
  logic [7:0]         pix_color_q, pix_color_d;
  logic               pix_vis_q, pix_vis_d;

  logic [GW-1:0] px_w, py_w, bx_lo, bx_end, by_lo, by_end;
  logic [GW-1:0] y_mid, hb_top, hb_end, hx_lo, hx_end;
  logic          hb_exists, body_hit, hb_hit, flash_on;

  always_comb begin
    x_d      = x_q;
    y_d      = y_q;
    w_d      = w_q;
    h_d      = h_q;
    color_d  = color_q;
    phase_d  = phase_q;
    facing_d = facing_q;
    if (frame_start_in) begin
      x_d      = char_x_pos_in;
      y_d      = char_y_pos_in;
      w_d      = char_width_in;
      h_d      = char_height_in;
      color_d  = char_color_in_332;
      phase_d  = attack_phase_in;
      facing_d = facing_left_in;
    end
  end

  // A hit in the same cycle as a frame start restarts the flash and skips the increment.
  always_comb begin
    state_d   = state_q;
    elapsed_d = elapsed_q;
    if (hit_pulse_in) begin
      state_d   = FLASHING;
      elapsed_d = '0;
    end else if ((state_q == FLASHING) && frame_start_in) begin
      if (elapsed_q == 8'(FLASH_FRAMES - 1)) begin
        state_d   = IDLE;
        elapsed_d = '0;
      end else begin
        elapsed_d = elapsed_q + 8'd1;
      end
    end
  end

  // Bounds are kept as exclusive ends two bits wider than a pixel coordinate, so
  // anything past the screen edge simply never matches (saturation, no wrap).
  always_comb begin
    px_w   = GW'(current_pixel_x);
    py_w   = GW'(current_pixel_y);
    bx_lo  = GW'(x_q);
    bx_end = GW'(x_q) + GW'(w_q);
    by_lo  = GW'(y_q);
    by_end = GW'(y_q) + GW'(h_q);
    y_mid  = GW'(y_q) + GW'(h_q >> 1);
    hb_top = (y_mid >= GW'(HITBOX_H / 2)) ? (y_mid - GW'(HITBOX_H / 2)) : '0;
    hb_end = hb_top + GW'(HITBOX_H);
    if (facing_q) begin
      hb_exists = (x_q != '0);
      hx_lo     = (GW'(x_q) >= GW'(HITBOX_W)) ? (GW'(x_q) - GW'(HITBOX_W)) : '0;
      hx_end    = GW'(x_q);
    end else begin
      hb_exists = 1'b1;
      hx_lo     = bx_end;
      hx_end    = bx_end + GW'(HITBOX_W);
    end

    body_hit = (px_w >= bx_lo) && (px_w < bx_end) && (py_w >= by_lo) && (py_w < by_end);
    hb_hit   = hb_exists && (phase_q != 2'b00) &&
               (px_w >= hx_lo) && (px_w < hx_end) && (py_w >= hb_top) && (py_w < hb_end);
    flash_on = (state_q == FLASHING) && !elapsed_q[PBIT];

    pix_vis_d   = 1'b0;
    pix_color_d = '0;
    if (display_enable) begin
      if (hb_hit) begin
        pix_vis_d = 1'b1;
        case (phase_q)
          2'b01:   pix_color_d = STARTUP_COLOR;
          2'b10:   pix_color_d = ACTIVE_COLOR;
          default: pix_color_d = RECOVERY_COLOR;
        endcase
      end else if (body_hit) begin
        pix_vis_d   = 1'b1;
        pix_color_d = flash_on ? HURT_COLOR : color_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q         <= '0;
      y_q         <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      phase_q     <= '0;
      facing_q    <= 1'b0;
      state_q     <= IDLE;
      elapsed_q   <= '0;
      pix_color_q <= '0;
      pix_vis_q   <= 1'b0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      phase_q     <= phase_d;
      facing_q    <= facing_d;
      state_q     <= state_d;
      elapsed_q   <= elapsed_d;
      pix_color_q <= pix_color_d;
      pix_vis_q   <= pix_vis_d;
    end
  end

  assign char_pixel_color_out_332     = pix_color_q;
  assign char_is_visible_at_pixel_out = pix_vis_q;
  assign flash_active_out             = (state_q == FLASHING);

endmodule

// File: tb/tb_char_sprite_renderer_reg.sv
// Scoreboard bench for char_sprite_renderer_reg: the driver pushes predictions
// from a rule-level reference model, a monitor pops and compares each cycle.
module tb_char_sprite_renderer_reg;
  localparam int CW   = 10;
  localparam int HBW  = 32;
  localparam int HBH  = 8;
  localparam int FF   = 16;
  localparam int FP   = 4;
  localparam int SMAX = 1023;
  localparam logic [7:0] HURT = 8'hFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start_in, display_enable, facing_left_in, hit_pulse_in;
  logic [CW-1:0] current_pixel_x, current_pixel_y;
  logic [CW-1:0] char_x_pos_in, char_y_pos_in, char_width_in, char_height_in;
  logic [7:0]    char_color_in_332;
  logic [1:0]    attack_phase_in;
  logic [7:0]    char_pixel_color_out_332;
  logic          char_is_visible_at_pixel_out, flash_active_out;

  char_sprite_renderer_reg #(
    .COORD_W(CW), .HITBOX_W(HBW), .HITBOX_H(HBH), .FLASH_FRAMES(FF), .FLASH_PERIOD(FP),
    .HURT_COLOR(HURT), .STARTUP_COLOR(8'b000_000_11), .ACTIVE_COLOR(8'b111_000_00),
    .RECOVERY_COLOR(8'b000_111_00)
  ) dut (
    .clk(clk), .rst(rst), .frame_start_in(frame_start_in), .display_enable(display_enable),
    .current_pixel_x(current_pixel_x), .current_pixel_y(current_pixel_y),
    .char_x_pos_in(char_x_pos_in), .char_y_pos_in(char_y_pos_in),
    .char_width_in(char_width_in), .char_height_in(char_height_in),
    .char_color_in_332(char_color_in_332), .attack_phase_in(attack_phase_in),
    .facing_left_in(facing_left_in), .hit_pulse_in(hit_pulse_in),
    .char_pixel_color_out_332(char_pixel_color_out_332),
    .char_is_visible_at_pixel_out(char_is_visible_at_pixel_out),
    .flash_active_out(flash_active_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         vis;
    logic [7:0] col;
    bit         fl;
    int         px;
    int         py;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: what the character looks like this frame, and the flash.
  int m_x, m_y, m_w, m_h, m_phase;
  logic [7:0] m_col;
  bit m_left, m_flash;
  int m_elapsed;

  function automatic int sat(input int v);
    return (v > SMAX) ? SMAX : v;
  endfunction

  function automatic logic [7:0] phase_color(input int ph);
    case (ph)
      1:       return 8'b000_000_11;
      2:       return 8'b111_000_00;
      default: return 8'b000_111_00;
    endcase
  endfunction

  function automatic void ref_pixel(input int px, input int py, input bit de,
                                    output bit vis, output logic [7:0] col);
    int t, hl, hr;
    bit in_body, in_hb;
    vis = 1'b0;
    col = 8'h00;
    if (!de) return;
    in_body = (px >= m_x) && (px <= sat(m_x + m_w - 1)) &&
              (py >= m_y) && (py <= sat(m_y + m_h - 1));
    t = m_y + m_h / 2 - HBH / 2;
    if (t < 0) t = 0;
    if (m_left) begin
      hl = m_x - HBW;
      if (hl < 0) hl = 0;
      hr = m_x - 1;
    end else begin
      hl = m_x + m_w;
      hr = sat(m_x + m_w + HBW - 1);
    end
    in_hb = (m_phase != 0) && (px >= hl) && (px <= hr) && (py >= t) && (py <= sat(t + HBH - 1));
    if (in_hb) begin
      vis = 1'b1;
      col = phase_color(m_phase);
    end else if (in_body) begin
      vis = 1'b1;
      col = (m_flash && ((m_elapsed / FP) % 2 == 0)) ? HURT : m_col;
    end
  endfunction

  function automatic int clampc(input int v);
    if (v < 0) return 0;
    return sat(v);
  endfunction

  // One pixel clock: drive inputs, predict, advance the model past the edge.
  task automatic step(input bit fs, input bit de, input int px, input int py, input bit hit);
    exp_t e;
    bit v;
    logic [7:0] c;
    int cx, cy;
    cx = clampc(px);
    cy = clampc(py);
    frame_start_in  = fs;
    display_enable  = de;
    current_pixel_x = cx[CW-1:0];
    current_pixel_y = cy[CW-1:0];
    hit_pulse_in    = hit;
    ref_pixel(cx, cy, de, v, c);
    if (fs) begin
      m_x     = int'(char_x_pos_in);
      m_y     = int'(char_y_pos_in);
      m_w     = int'(char_width_in);
      m_h     = int'(char_height_in);
      m_col   = char_color_in_332;
      m_phase = int'(attack_phase_in);
      m_left  = facing_left_in;
    end
    if (hit) begin
      m_flash   = 1'b1;
      m_elapsed = 0;
    end else if (m_flash && fs) begin
      m_elapsed++;
      if (m_elapsed == FF) begin
        m_flash   = 1'b0;
        m_elapsed = 0;
      end
    end
    e.vis = v;
    e.col = c;
    e.fl  = m_flash;
    e.px  = cx;
    e.py  = cy;
    q.push_back(e);
    @(posedge clk);
    #2;
    frame_start_in = 1'b0;
    hit_pulse_in   = 1'b0;
  endtask

  task automatic set_char(input int x, input int y, input int w, input int h,
                          input logic [7:0] c, input int ph, input bit left);
    char_x_pos_in     = x[CW-1:0];
    char_y_pos_in     = y[CW-1:0];
    char_width_in     = w[CW-1:0];
    char_height_in    = h[CW-1:0];
    char_color_in_332 = c;
    attack_phase_in   = ph[1:0];
    facing_left_in    = left;
  endtask

  task automatic check_zero(input string name);
    n_tests++;
    if (char_pixel_color_out_332 !== 8'h00 || char_is_visible_at_pixel_out !== 1'b0 ||
        flash_active_out !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: got col=%02h vis=%0b flash=%0b, want all 0", name,
               char_pixel_color_out_332, char_is_visible_at_pixel_out, flash_active_out);
    end
  endtask

  // Asynchronous: outputs must clear before any clock edge arrives.
  task automatic apply_reset(input string name);
    rst = 1'b1;
    #1;
    check_zero(name);
    m_x = 0; m_y = 0; m_w = 0; m_h = 0; m_col = 8'h00; m_phase = 0; m_left = 1'b0;
    m_flash = 1'b0; m_elapsed = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  task automatic random_run(input int n);
    bit fs, hit, de;
    int px, py;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 11) == 0)
        set_char(($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom_range(0, 900),
                 $urandom_range(0, 900), $urandom_range(1, 100), $urandom_range(1, 100),
                 8'($urandom_range(0, 255)), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      fs  = ($urandom_range(0, 15) == 0);
      hit = ($urandom_range(0, 40) == 0);
      de  = ($urandom_range(0, 7) != 0);
      px  = m_x - HBW - 4 + $urandom_range(0, m_w + 2 * HBW + 8);
      py  = m_y - 6 + $urandom_range(0, m_h + 12);
      step(fs, de, px, py, hit);
    end
  endtask

  // Monitor: one registered output per issued pixel.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_tests++;
        if (char_is_visible_at_pixel_out !== e.vis || char_pixel_color_out_332 !== e.col ||
            flash_active_out !== e.fl) begin
          n_fail++;
          $display("FAIL pix(%0d,%0d): got vis=%0b col=%02h flash=%0b, want vis=%0b col=%02h flash=%0b",
                   e.px, e.py, char_is_visible_at_pixel_out, char_pixel_color_out_332,
                   flash_active_out, e.vis, e.col, e.fl);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    frame_start_in = 1'b0; display_enable = 1'b0; hit_pulse_in = 1'b0;
    current_pixel_x = '0; current_pixel_y = '0;
    set_char(0, 0, 0, 0, 8'h00, 0, 1'b0);
    #2;
    apply_reset("reset_initial");

    // Body only
    step(0, 1, 100, 200, 0);
    set_char(100, 200, 20, 40, 8'h1C, 0, 1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 100, 200, 0);
    step(0, 1, 120, 220, 0);
    step(0, 1, 99, 200, 0);
    step(0, 1, 119, 239, 0);
    step(0, 1, 100, 240, 0);
    step(0, 0, 110, 210, 0);

    // Active hitbox facing right
    set_char(100, 200, 20, 40, 8'h1C, 2, 1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 120, 216, 0);
    step(0, 1, 151, 223, 0);
    step(0, 1, 152, 223, 0);
    step(0, 1, 120, 224, 0);
    step(0, 1, 120, 215, 0);
    step(0, 1, 119, 216, 0);

    // Facing left with clipping, then at the screen edge, then other phases
    set_char(10, 200, 20, 40, 8'h1C, 2, 1'b1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 216, 0);
    step(0, 1, 9, 223, 0);
    step(0, 1, 10, 216, 0);
    step(0, 1, 0, 224, 0);
    set_char(0, 200, 20, 40, 8'h1C, 2, 1'b1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 216, 0);
    step(0, 1, 1023, 216, 0);
    step(0, 1, 1000, 220, 0);
    set_char(40, 200, 20, 40, 8'h1C, 1, 1'b1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 8, 216, 0);
    step(0, 1, 7, 216, 0);
    set_char(40, 200, 20, 40, 8'h1C, 3, 1'b1);
    step(1, 0, 0, 0, 0);
    step(0, 1, 39, 223, 0);

    // Top clamp and right-edge saturation
    set_char(50, 2, 10, 4, 8'h55, 2, 1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 60, 0, 0);
    step(0, 1, 91, 7, 0);
    step(0, 1, 60, 8, 0);
    set_char(1000, 100, 20, 20, 8'h55, 2, 1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1023, 106, 0);
    step(0, 1, 1019, 106, 0);
    step(0, 1, 1020, 113, 0);
    step(0, 1, 1020, 114, 0);

    // Inputs change mid-frame: no effect until the next frame start
    set_char(100, 200, 20, 40, 8'h1C, 0, 1'b0);
    step(1, 0, 0, 0, 0);
    set_char(300, 200, 20, 40, 8'h1C, 0, 1'b0);
    step(0, 1, 100, 200, 0);
    step(0, 1, 300, 200, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 100, 200, 0);
    step(0, 1, 300, 200, 0);

    // Full flash cycle
    set_char(100, 200, 20, 40, 8'h1C, 2, 1'b0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 110, 210, 1);
    for (int f = 0; f < FF; f++) begin
      step(0, 1, 110, 210, 0);
      step(0, 1, 125, 220, 0);
      step(1, 0, 0, 0, 0);
    end
    step(0, 1, 110, 210, 0);

    // Restart at frame 5
    step(0, 1, 110, 210, 1);
    for (int f = 0; f < 5; f++) begin
      step(0, 1, 110, 210, 0);
      step(1, 0, 0, 0, 0);
    end
    step(0, 1, 110, 210, 1);
    for (int f = 0; f < 10; f++) begin
      step(0, 1, 110, 210, 0);
      step(1, 0, 0, 0, 0);
    end

    // Hit coincident with frame start, then reset mid-flash
    step(1, 1, 110, 210, 1);
    step(0, 1, 110, 210, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 110, 210, 0);
    apply_reset("reset_midflash");
    step(0, 1, 110, 210, 0);
    step(1, 0, 0, 0, 0);
    step(0, 1, 110, 210, 0);

    random_run(600);

    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
